arcade_input_ctrl: RTL
======================

ARCADE_INPUT_CTRL -- requirements
Module: arcade_input_ctrl

Interface
REQ-001 Parameter NUM_PLAYERS, 2: joystick sources; range 2..4.
REQ-002 Parameter NUM_BUTTONS, 3: fire buttons per player; range 1..8.
REQ-003 Parameter COIN_PULSE_LEN, 8: coin pulse high time, in ce_tick periods; range 1..255.
REQ-004 Parameter COIN_GAP_LEN, 8: minimum coin low time between pulses, in ce_tick periods; range 1..255.
REQ-005 Parameter COIN_ON_START, 1: a start press also inserts a coin when 1.
REQ-006 clk_sys  in  1  system clock; one clock; reset is synchronous and active-high.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 ce_tick  in  1  one-cycle timebase strobe for coin timing.
REQ-009 joy_in  in  NUM_PLAYERS*16  player k at [16k+15:16k]; bit0 right, 1 left, 2 down, 3 up, 4..3+NUM_BUTTONS fire, 4+NUM_BUTTONS start, 5+NUM_BUTTONS coin.
REQ-010 cocktail  in  1  0 upright, 1 cocktail.
REQ-011 autofire  in  NUM_PLAYERS  per-player autofire enable (used only under AUTOFIRE_EN).
REQ-012 dir_p1, dir_p2  out  4 each  cleaned directions {up,down,left,right}.
REQ-013 btn_p1, btn_p2  out  NUM_BUTTONS each  fire buttons.
REQ-014 start_out  out  NUM_PLAYERS  start buttons.
REQ-015 coin_out  out  1  timed coin pulse.
REQ-016 coin_pending  out  2  queued coins not yet pulsed.

Function
REQ-017 Upright: p1 and p2 outputs each equal the bitwise OR of all players' controls; cocktail: p1 from player 0, p2 from player 1; players 2+ are ignored for dir and btn in cocktail.
REQ-018 Opposite directions cancel: left and right both set -> both 0; up and down both set -> both 0; applied after the OR.
REQ-019 All direction, button and start outputs are registered, with exactly one clk_sys cycle latency from joy_in.
REQ-020 Coin request: rising edge, detected per clk_sys cycle, of any player's coin bit, or of any start bit when COIN_ON_START=1; multiple edges in one cycle count as one request.
REQ-021 coin_pending increments on each request and saturates at 3; further requests are dropped.
REQ-022 Coin FSM states: IDLE, PULSE, GAP; IDLE->PULSE on the first clk_sys cycle with coin_pending>0, decrementing coin_pending; PULSE->GAP after COIN_PULSE_LEN ce_ticks; GAP->PULSE after COIN_GAP_LEN ce_ticks if coin_pending>0, else GAP->IDLE.
REQ-023 coin_out is 1 exactly while in PULSE; tick counting uses an 8-bit counter that advances only on ce_tick.
REQ-024 A request coinciding with a decrement leaves coin_pending unchanged.
REQ-025 Toggling cocktail mid-game takes effect on the next cycle; coin FSM is unaffected.

Reset
REQ-026 On reset, all outputs go to 0, FSM goes to IDLE, coin_pending to 0, and edge-detect history is loaded with the current joy_in so that held buttons produce no coin.
REQ-027 Reset during PULSE terminates the pulse in the same cycle reset is sampled.

Configuration
REQ-028 Macro ARCADE_INPUT_AUTOFIRE_EN defined: for player k with autofire[k]=1, holding fire button 0 produces a square wave, 4 ce_ticks on and 4 off, starting on at press; release gives 0 next cycle.
REQ-029 Macro ARCADE_INPUT_AUTOFIRE_EN not defined: fire button 0 passes straight through, autofire is ignored, and no autofire counters exist.

Structure
REQ-030 Package arcade_input_pkg holds the joystick bit-index constants (JOY_RIGHT..JOY_UP, JOY_FIRE0), the start/coin index functions of NUM_BUTTONS, and the coin FSM state enum.
REQ-031 Sub-module coin_pulser contains edge-free request input, pending counter, FSM and tick counter; the top module instantiates it once.

Verification
REQ-032 Upright, joy0 right=1, joy1 left=1 -> dir_p1=dir_p2=0000 (cancelled) one cycle later.
REQ-033 Cocktail, joy1 up=1 only -> dir_p2=1000, dir_p1=0000.
REQ-034 ce_tick every 4 cycles, single coin press -> coin_out high 32 cycles, coin_pending 1->0 at pulse start.
REQ-035 Five coin presses within one pulse -> coin_pending saturates at 3; exactly 4 pulses total, each separated by >=COIN_GAP_LEN ticks low.
REQ-036 Coin held across reset release -> no pulse; reset asserted mid-PULSE -> coin_out 0 on the next cycle.
REQ-037 With ARCADE_INPUT_AUTOFIRE_EN defined and autofire[0]=1, fire0 held -> btn_p1[0] toggles every 4 ce_ticks; without the macro, it stays 1.

Source files
------------

// File: rtl/arcade_input_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arcade_input_pkg
// Description : Shared definitions for the arcade input controller.
//               - Joystick bit-index constants within a 16-bit player word.
//               - Start/coin index helpers that depend on NUM_BUTTONS.
//               - Coin FSM state enum.
//               - Opposite-direction cancel helper.
//               Optional feature macro used by the slice:
//               ARCADE_INPUT_AUTOFIRE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package arcade_input_pkg;

  localparam int JOY_WIDTH = 16;
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_FIRE0 = 4;

  // Start sits directly above the fire buttons, coin directly above start.
  function automatic int joy_start_idx(input int num_buttons);
    return JOY_FIRE0 + num_buttons;
  endfunction

  function automatic int joy_coin_idx(input int num_buttons);
    return JOY_FIRE0 + num_buttons + 1;
  endfunction

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_GAP   = 2'd2
  } coin_state_t;

  // Direction vector is {up, down, left, right}; a pair pressed together
  // means "neither".
  function automatic logic [3:0] cancel_opposite(input logic [3:0] d);
    logic [3:0] r;
    r = d;
    if (d[JOY_RIGHT] && d[JOY_LEFT]) r[1:0] = 2'b00;
    if (d[JOY_DOWN] && d[JOY_UP])    r[3:2] = 2'b00;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arcade_input_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : arcade_input_ctrl_if
// Description : Bus interface of the arcade input controller.
//   joy_in       : NUM_PLAYERS*16 raw joystick words
//   cocktail     : 0 upright, 1 cocktail
//   autofire     : per-player autofire enable
//   dir_p1/p2    : cleaned directions {up,down,left,right}
//   btn_p1/p2    : fire buttons
//   start_out    : per-player start buttons
//   coin_out     : timed coin pulse
//   coin_pending : queued coins not yet pulsed
//   master drives the controls, slave (the controller) drives the results.
// Revision    : 1.0 - initial release
// ============================================================================
interface arcade_input_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BUTTONS = 3
);
  logic [NUM_PLAYERS*16-1:0] joy_in;
  logic                      cocktail;
  logic [NUM_PLAYERS-1:0]    autofire;
  logic [3:0]                dir_p1;
  logic [3:0]                dir_p2;
  logic [NUM_BUTTONS-1:0]    btn_p1;
  logic [NUM_BUTTONS-1:0]    btn_p2;
  logic [NUM_PLAYERS-1:0]    start_out;
  logic                      coin_out;
  logic [1:0]                coin_pending;

  modport master (
    output joy_in, cocktail, autofire,
    input  dir_p1, dir_p2, btn_p1, btn_p2, start_out, coin_out, coin_pending
  );

  modport slave (
    input  joy_in, cocktail, autofire,
    output dir_p1, dir_p2, btn_p1, btn_p2, start_out, coin_out, coin_pending
  );
endinterface
`default_nettype wire

// File: rtl/arcade_input_ctrl_coin_pulser.sv
`default_nettype none
// ============================================================================
// Module      : coin_pulser
// Description : Coin request queue and pulse timer.
//   clk, rst   : clock, synchronous active-high reset
//   i_ce_tick  : timebase strobe; only ticks advance the pulse/gap timer
//   i_req      : single-cycle coin request (already edge-detected)
//   o_coin     : high for PULSE_LEN ticks per queued coin
//   o_pending  : queued coins, saturating at 3
// Revision    : 1.0 - initial release
// ============================================================================
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int PULSE_LEN = 8,
  parameter int GAP_LEN   = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_ce_tick,
  input  wire logic       i_req,
  output logic            o_coin,
  output logic [1:0]      o_pending
);

  localparam logic [7:0] c_PULSE_LAST = 8'(PULSE_LEN - 1);
  localparam logic [7:0] c_GAP_LAST   = 8'(GAP_LEN - 1);

  coin_state_t r_state;
  logic [7:0]  r_tick_cnt;
  logic [1:0]  r_pend;
  logic        r_coin;
  logic        w_dec;

  // A queued coin is consumed when a new pulse is launched.
  always_comb begin
    w_dec = 1'b0;
    if (r_pend != 2'd0) begin
      if (r_state == COIN_IDLE)
        w_dec = 1'b1;
      else if (r_state == COIN_GAP && i_ce_tick && r_tick_cnt == c_GAP_LAST)
        w_dec = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= COIN_IDLE;
      r_tick_cnt <= 8'd0;
      r_pend     <= 2'd0;
      r_coin     <= 1'b0;
    end else begin
      // Request and consume in the same cycle cancel out.
      if (i_req && !w_dec && r_pend != 2'd3)
        r_pend <= r_pend + 2'd1;
      else if (!i_req && w_dec)
        r_pend <= r_pend - 2'd1;

      case (r_state)
        COIN_IDLE: begin
          r_tick_cnt <= 8'd0;
          if (r_pend != 2'd0) begin
            r_state <= COIN_PULSE;
            r_coin  <= 1'b1;
          end
        end
        COIN_PULSE: begin
          if (i_ce_tick) begin
            if (r_tick_cnt == c_PULSE_LAST) begin
              r_tick_cnt <= 8'd0;
              r_state    <= COIN_GAP;
              r_coin     <= 1'b0;
            end else begin
              r_tick_cnt <= r_tick_cnt + 8'd1;
            end
          end
        end
        COIN_GAP: begin
          if (i_ce_tick) begin
            if (r_tick_cnt == c_GAP_LAST) begin
              r_tick_cnt <= 8'd0;
              if (r_pend != 2'd0) begin
                r_state <= COIN_PULSE;
                r_coin  <= 1'b1;
              end else begin
                r_state <= COIN_IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 8'd1;
            end
          end
        end
        default: begin
          r_state    <= COIN_IDLE;
          r_tick_cnt <= 8'd0;
          r_coin     <= 1'b0;
        end
      endcase
    end
  end

  assign o_coin    = r_coin;
  assign o_pending = r_pend;

endmodule
`default_nettype wire

// File: rtl/arcade_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arcade_input_ctrl
// Description : Merges several joystick sources into two player outputs
//               (upright = OR of all players, cocktail = player 0 / 1),
//               cancels opposite directions, registers everything with one
//               cycle latency and turns coin/start presses into timed coin
//               pulses.
//   clk_sys  : system clock
//   reset    : synchronous active-high reset
//   ce_tick  : timebase strobe for coin (and autofire) timing
//   bus      : arcade_input_ctrl_if.slave (joy_in, cocktail, autofire in;
//              dir/btn/start/coin results out)
//   Optional macro: ARCADE_INPUT_AUTOFIRE_EN - square-wave autofire on fire
//               button 0 (4 ticks on, 4 off) for players with autofire set.
// Revision    : 1.0 - initial release
// ============================================================================
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS    = 2,
  parameter int NUM_BUTTONS    = 3,
  parameter int COIN_PULSE_LEN = 8,
  parameter int COIN_GAP_LEN   = 8,
  parameter int COIN_ON_START  = 1
) (
  input  wire logic     clk_sys,
  input  wire logic     reset,
  input  wire logic     ce_tick,
  arcade_input_ctrl_if.slave bus
);

  localparam int c_START_IDX = joy_start_idx(NUM_BUTTONS);
  localparam int c_COIN_IDX  = joy_coin_idx(NUM_BUTTONS);

  logic [3:0]             w_dir [NUM_PLAYERS];
  logic [NUM_BUTTONS-1:0] w_btn [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] w_start;
  logic [NUM_PLAYERS-1:0] w_coin;

  genvar gk;
  generate
    for (gk = 0; gk < NUM_PLAYERS; gk++) begin : g_player
      localparam int c_base = JOY_WIDTH * gk;
      logic w_fire0;

`ifdef ARCADE_INPUT_AUTOFIRE_EN
      // Phase counter restarts at every press so the wave begins "on".
      logic [2:0] r_af_cnt;
      always_ff @(posedge clk_sys) begin
        if (reset || !bus.joy_in[c_base + JOY_FIRE0])
          r_af_cnt <= 3'd0;
        else if (ce_tick)
          r_af_cnt <= r_af_cnt + 3'd1;
      end
      assign w_fire0 = bus.joy_in[c_base + JOY_FIRE0] &
                       ~(bus.autofire[gk] & r_af_cnt[2]);
`else
      assign w_fire0 = bus.joy_in[c_base + JOY_FIRE0];
`endif

      assign w_dir[gk] = {bus.joy_in[c_base + JOY_UP],
                          bus.joy_in[c_base + JOY_DOWN],
                          bus.joy_in[c_base + JOY_LEFT],
                          bus.joy_in[c_base + JOY_RIGHT]};

      if (NUM_BUTTONS > 1) begin : g_multi_btn
        assign w_btn[gk] = {bus.joy_in[c_base + JOY_FIRE0 + 1 +: NUM_BUTTONS - 1],
                            w_fire0};
      end else begin : g_single_btn
        assign w_btn[gk] = w_fire0;
      end

      assign w_start[gk] = bus.joy_in[c_base + c_START_IDX];
      assign w_coin[gk]  = bus.joy_in[c_base + c_COIN_IDX];
    end
  endgenerate

  // Spare joystick bits (and autofire in the plain build) are intentionally
  // ignored.
  logic w_unused;
  assign w_unused = ^{bus.joy_in, bus.autofire};

  logic [3:0]             w_dir_or;
  logic [NUM_BUTTONS-1:0] w_btn_or;
  always_comb begin
    w_dir_or = 4'd0;
    w_btn_or = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      w_dir_or = w_dir_or | w_dir[k];
      w_btn_or = w_btn_or | w_btn[k];
    end
  end

  logic [3:0]             w_dir_p1, w_dir_p2;
  logic [NUM_BUTTONS-1:0] w_btn_p1, w_btn_p2;
  assign w_dir_p1 = bus.cocktail ? w_dir[0] : w_dir_or;
  assign w_dir_p2 = bus.cocktail ? w_dir[1] : w_dir_or;
  assign w_btn_p1 = bus.cocktail ? w_btn[0] : w_btn_or;
  assign w_btn_p2 = bus.cocktail ? w_btn[1] : w_btn_or;

  logic [3:0]             r_dir_p1, r_dir_p2;
  logic [NUM_BUTTONS-1:0] r_btn_p1, r_btn_p2;
  logic [NUM_PLAYERS-1:0] r_start;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_dir_p1 <= 4'd0;
      r_dir_p2 <= 4'd0;
      r_btn_p1 <= '0;
      r_btn_p2 <= '0;
      r_start  <= '0;
    end else begin
      r_dir_p1 <= cancel_opposite(w_dir_p1);
      r_dir_p2 <= cancel_opposite(w_dir_p2);
      r_btn_p1 <= w_btn_p1;
      r_btn_p2 <= w_btn_p2;
      r_start  <= w_start;
    end
  end

  // Edge history is loaded during reset as well, so buttons held through
  // reset release never look like a fresh press.
  logic [2*NUM_PLAYERS-1:0] w_coin_src;
  logic [2*NUM_PLAYERS-1:0] r_coin_hist;
  logic                     w_coin_req;

  assign w_coin_src = {(COIN_ON_START != 0) ? w_start : {NUM_PLAYERS{1'b0}}, w_coin};

  always_ff @(posedge clk_sys) begin
    r_coin_hist <= w_coin_src;
  end

  assign w_coin_req = |(w_coin_src & ~r_coin_hist);

  logic       w_coin_out;
  logic [1:0] w_coin_pending;

  coin_pulser #(
    .PULSE_LEN (COIN_PULSE_LEN),
    .GAP_LEN   (COIN_GAP_LEN)
  ) u_coin_pulser (
    .clk       (clk_sys),
    .rst       (reset),
    .i_ce_tick (ce_tick),
    .i_req     (w_coin_req),
    .o_coin    (w_coin_out),
    .o_pending (w_coin_pending)
  );

  assign bus.dir_p1       = r_dir_p1;
  assign bus.dir_p2       = r_dir_p2;
  assign bus.btn_p1       = r_btn_p1;
  assign bus.btn_p2       = r_btn_p2;
  assign bus.start_out    = r_start;
  assign bus.coin_out     = w_coin_out;
  assign bus.coin_pending = w_coin_pending;

endmodule
`default_nettype wire
